// File: rtl/mac_core_axil_regs.sv
// mac_core_axil_regs: AXI4-Lite slave holding four 32-bit MAC control registers
// Ports:
//   ACLK, ARESET          clock and asynchronous active-high reset
//   S_AXI_AW*/W*/B*       write address, data and response channels (single beat, OKAY only)
//   S_AXI_AR*/R*          read address and data channels (1-cycle read latency)
//   REG_OUT               {reg3,reg2,reg1,reg0} to the MAC datapath
//   REG_WR_PULSE          one-cycle strobe, bit i set when reg i is committed
module mac_core_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT,
    output logic [3:0]                        REG_WR_PULSE
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    logic [3:0][DW-1:0] regs;
    logic aw_held, w_held, bvalid, rvalid;
    logic [1:0] aw_idx, wr_idx;
    logic [DW-1:0] w_data, wr_data, wr_word, rdata;
    logic [SW-1:0] w_strb, wr_strb;
    logic [3:0] pulse;
    logic aw_hs, w_hs, ar_hs, commit;
    logic unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ~aw_held & ~bvalid;
    assign S_AXI_WREADY  = ~w_held & ~bvalid;
    assign S_AXI_ARREADY = ~rvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign REG_OUT       = regs;
    assign REG_WR_PULSE  = pulse;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);

    // A held beat takes precedence over the live bus, since a held channel is not ready.
    assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[3:2];
    assign wr_data = w_held ? w_data : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;

    always_comb begin
        wr_word = regs[wr_idx];
        for (int b = 0; b < SW; b++)
            wr_word[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : regs[wr_idx][8*b +: 8];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs    <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            pulse   <= '0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            aw_held <= ~commit & (aw_held | aw_hs);
            w_held  <= ~commit & (w_held | w_hs);
            if (aw_hs) aw_idx <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) regs[wr_idx] <= wr_word;
            pulse  <= commit ? 4'b0001 << wr_idx : 4'b0000;
            bvalid <= commit | (bvalid & ~S_AXI_BREADY);
            // Sampled from the pre-commit register value on a coincident write.
            if (ar_hs) rdata <= regs[S_AXI_ARADDR[3:2]];
            rvalid <= ar_hs | (rvalid & ~S_AXI_RREADY);
        end
    end
endmodule

// File: tb/tb_mac_core_axil_regs.sv
// tb_mac_core_axil_regs: directed self-checking bench for mac_core_axil_regs
module tb_mac_core_axil_regs;
    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [3:0]   AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [3:0]   ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [127:0] REG_OUT;
    logic [3:0]   REG_WR_PULSE;

    int errors = 0;
    int checks = 0;

    mac_core_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .REG_OUT(REG_OUT), .REG_WR_PULSE(REG_WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic a_acc, w_acc;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while ((AWVALID || WVALID) && n < 20) begin
            a_acc = AWVALID & AWREADY;
            w_acc = WVALID & WREADY;
            tick();
            if (a_acc) AWVALID = 1'b0;
            if (w_acc) WVALID = 1'b0;
            n++;
        end
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        checks++;
        if (!BVALID) begin errors++; $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, BVALID); end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin tick(); n++; end
        checks++;
        if (!RVALID) begin errors++; $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, RVALID); end
        d = RDATA;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        tick(); tick();
        ARESET = 1'b0;
        tick();
        checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL reset_ready got=%b required=111", {AWREADY, WREADY, ARREADY}); end
        checks++; if ({BVALID, RVALID} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b required=00", {BVALID, RVALID}); end
        checks++; if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h required=0", RDATA); end
        checks++; if (REG_WR_PULSE !== 4'h0) begin errors++; $display("FAIL reset_pulse got=%b required=0000", REG_WR_PULSE); end
        checks++; if (REG_OUT !== 128'h0) begin errors++; $display("FAIL reset_regs got=%h required=0", REG_OUT); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'(i + 1);
            AWADDR = 4'(4 * i); WDATA = exp_d; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
            checks++; if ({AWREADY, WREADY} !== 2'b11) begin errors++; $display("FAIL wr_ready[%0d] got=%b required=11", i, {AWREADY, WREADY}); end
            tick();
            AWVALID = 1'b0; WVALID = 1'b0;
            checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL bresp[%0d] got=%b/%b required=1/00", i, BVALID, BRESP); end
            checks++; if (REG_WR_PULSE !== 4'(1 << i)) begin errors++; $display("FAIL pulse[%0d] got=%b required=%b", i, REG_WR_PULSE, 4'(1 << i)); end
            checks++; if (REG_OUT[32*i +: 32] !== exp_d) begin errors++; $display("FAIL regval[%0d] got=%h required=%h", i, REG_OUT[32*i +: 32], exp_d); end
            BREADY = 1'b1;
            tick();
            BREADY = 1'b0;
            checks++; if (BVALID !== 1'b0 || REG_WR_PULSE !== 4'h0) begin errors++; $display("FAIL bdone[%0d] got=%b/%b required=0/0000", i, BVALID, REG_WR_PULSE); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'(i + 1);
            ARADDR = 4'(4 * i); ARVALID = 1'b1;
            checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL arready[%0d] got=%b required=1", i, ARREADY); end
            tick();
            ARVALID = 1'b0;
            checks++; if (RVALID !== 1'b1 || RDATA !== exp_d || RRESP !== 2'b00) begin errors++; $display("FAIL rd[%0d] got=%b/%h/%b required=1/%h/00", i, RVALID, RDATA, RRESP, exp_d); end
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
            checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL rdone[%0d] got=%b required=0", i, RVALID); end
        end
    endtask

    task automatic test_w_leads();
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        checks++; if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin errors++; $display("FAIL w_held_ready got=%b%b required=01", WREADY, AWREADY); end
        tick(); tick();
        checks++; if (BVALID !== 1'b0 || REG_OUT[95:64] !== 32'h3) begin errors++; $display("FAIL w_lead_early got=%b/%h required=0/00000003", BVALID, REG_OUT[95:64]); end
        AWADDR = 4'h8; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        checks++; if (BVALID !== 1'b1 || REG_WR_PULSE !== 4'b0100) begin errors++; $display("FAIL w_lead_commit got=%b/%b required=1/0100", BVALID, REG_WR_PULSE); end
        checks++; if (REG_OUT[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL w_lead_reg2 got=%h required=deadbeef", REG_OUT[95:64]); end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        do_write(4'h4, 32'hFFFFFFFF, 4'hF);
        do_write(4'h4, 32'h12345678, 4'b0101);
        do_read(4'h4, d);
        checks++; if (d !== 32'hFF34FF78) begin errors++; $display("FAIL strobe_merge got=%h required=ff34ff78", d); end
        do_write(4'h7, 32'hCAFE0000, 4'b1100);
        checks++; if (REG_OUT[63:32] !== 32'hCAFEFF78) begin errors++; $display("FAIL unaligned_upper got=%h required=cafeff78", REG_OUT[63:32]); end
        AWADDR = 4'hC; WDATA = 32'hFFFFFFFF; WSTRB = 4'h0; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00 || REG_WR_PULSE !== 4'b1000) begin errors++; $display("FAIL zero_strb_resp got=%b/%b/%b required=1/00/1000", BVALID, BRESP, REG_WR_PULSE); end
        checks++; if (REG_OUT[127:96] !== 32'h4) begin errors++; $display("FAIL zero_strb_reg got=%h required=00000004", REG_OUT[127:96]); end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_back_to_back();
        AWADDR = 4'h0; WDATA = 32'h11; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWADDR = 4'h4; WDATA = 32'h99;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({BVALID, AWREADY, WREADY} !== 3'b100) begin errors++; $display("FAIL bp_hold[%0d] got=%b required=100", i, {BVALID, AWREADY, WREADY}); end
            tick();
        end
        checks++; if (REG_OUT[63:32] !== 32'hCAFEFF78 || REG_OUT[31:0] !== 32'h11) begin errors++; $display("FAIL bp_no_accept got=%h_%h required=cafeff78_00000011", REG_OUT[63:32], REG_OUT[31:0]); end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        checks++; if ({BVALID, AWREADY, WREADY} !== 3'b011) begin errors++; $display("FAIL bp_release got=%b required=011", {BVALID, AWREADY, WREADY}); end
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++; if (BVALID !== 1'b1 || REG_WR_PULSE !== 4'b0010 || REG_OUT[63:32] !== 32'h99) begin errors++; $display("FAIL bp_second got=%b/%b/%h required=1/0010/00000099", BVALID, REG_WR_PULSE, REG_OUT[63:32]); end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_read_hold();
        logic [31:0] d;
        ARADDR = 4'h0; ARVALID = 1'b1;
        tick();
        ARADDR = 4'h4;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({RVALID, ARREADY} !== 2'b10 || RDATA !== 32'h11) begin errors++; $display("FAIL rd_hold[%0d] got=%b/%h required=10/00000011", i, {RVALID, ARREADY}, RDATA); end
            tick();
        end
        ARVALID = 1'b0; RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        AWADDR = 4'h0; WDATA = 32'hA5; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h0; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'h11) begin errors++; $display("FAIL rd_collide_old got=%b/%h required=1/00000011", RVALID, RDATA); end
        checks++; if (BVALID !== 1'b1 || REG_OUT[31:0] !== 32'hA5) begin errors++; $display("FAIL rd_collide_wr got=%b/%h required=1/000000a5", BVALID, REG_OUT[31:0]); end
        RREADY = 1'b1; BREADY = 1'b1;
        tick();
        RREADY = 1'b0; BREADY = 1'b0;
        do_read(4'h0, d);
        checks++; if (d !== 32'hA5) begin errors++; $display("FAIL rd_after_collide got=%h required=000000a5", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        AWADDR = 4'h8; WDATA = 32'h1234; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h8; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        checks++; if ({BVALID, RVALID} !== 2'b11) begin errors++; $display("FAIL mid_pre got=%b required=11", {BVALID, RVALID}); end
        ARESET = 1'b1;
        #2;
        checks++; if ({BVALID, RVALID, REG_WR_PULSE} !== 6'b0) begin errors++; $display("FAIL mid_async_valid got=%b required=000000", {BVALID, RVALID, REG_WR_PULSE}); end
        checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111 || RDATA !== 32'h0 || REG_OUT !== 128'h0) begin errors++; $display("FAIL mid_async_state got=%b/%h/%h required=111/0/0", {AWREADY, WREADY, ARREADY}, RDATA, REG_OUT); end
        ARESET = 1'b0;
        tick();
        WDATA = 32'h55; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        ARESET = 1'b1;
        #2;
        ARESET = 1'b0;
        tick();
        AWADDR = 4'h0; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        tick();
        checks++; if (BVALID !== 1'b0 || REG_OUT[31:0] !== 32'h0) begin errors++; $display("FAIL partial_discard got=%b/%h required=0/0", BVALID, REG_OUT[31:0]); end
        ARESET = 1'b1;
        #2;
        ARESET = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            do_read(4'(4 * i), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_rd[%0d] got=%h required=0", i, d); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_same_cycle();
        test_w_leads();
        test_strobe();
        test_back_to_back();
        test_read_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
